fir_serial_mac_16: RTL and testbench

FIR_SERIAL_MAC_16 -- requirements
Module: fir_serial_mac_16

---
 rtl/fir_serial_mac_16.sv | 154 +++++++++++++++
 tb/tb_fir_serial_mac_16.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mac_16.sv
// Serial 16-tap FIR filter. One multiply-accumulate per clock, so a sample
// takes 18 clocks from acceptance to the next possible acceptance. The
// coefficient bank is writable only while idle and resets to a unity
// pass-through (h[0] = 1.0 in Q2.14, all other taps zero).
//
// Handshake: o_ready is high only in IDLE. A sample is taken on a rising edge
// where i_sample_valid && o_ready. A strobe on any other edge is discarded and
// sets the sticky o_drop flag. o_filtered_valid is a one-cycle pulse with no
// back-pressure.
module fir_serial_mac_16 #(
    parameter int NTAPS     = 16,
    parameter int COEF_W    = 16,
    parameter int OUT_SHIFT = 14
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [13:0] i14_sample,
    input  logic        i_sample_valid,
    output logic        o_ready,
    input  logic        i_coef_we,
    input  logic [3:0]  i4_coef_addr,
    input  logic [15:0] i16_coef_data,
    output logic [13:0] o14_filtered,
    output logic        o_filtered_valid,
    output logic        o_saturated,
    output logic        o_drop,
    output logic [1:0]  o2_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [3:0] LAST_TAP = 4'(NTAPS - 1);

    logic [1:0]               state_q;
    logic [3:0]               tap_q;
    logic signed [33:0]       acc_q;
    logic signed [13:0]       x_q [NTAPS];
    logic signed [COEF_W-1:0] h_q [NTAPS];

    logic                     accept;
    logic signed [29:0]       prod;
    logic signed [33:0]       acc_rnd;
    logic signed [33:0]       acc_sh;
    logic [13:0]              sat_val;
    logic                     sat_flag;

    assign o_ready      = (state_q == ST_IDLE);
    assign o2_dbg_state = state_q;
    assign accept       = i_sample_valid && o_ready;

    // Product of the tap currently addressed by the counter; the 34-bit
    // accumulator has 4 guard bits so 16 full-scale products cannot overflow.
    assign prod = x_q[tap_q] * h_q[tap_q];

    // Round half up, arithmetic shift back to sample scale, clip to 14 bits.
    always_comb begin
        acc_rnd  = acc_q + (34'sd1 <<< (OUT_SHIFT - 1));
        acc_sh   = acc_rnd >>> OUT_SHIFT;
        sat_val  = acc_sh[13:0];
        sat_flag = 1'b0;
        if (acc_sh > 34'sd8191) begin
            sat_val  = 14'h1fff;
            sat_flag = 1'b1;
        end else if (acc_sh < -34'sd8192) begin
            sat_val  = 14'h2000;
            sat_flag = 1'b1;
        end
    end

    // Sequencer: IDLE -> MAC (16 taps) -> OUT -> IDLE, with tap counter and accumulator.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            tap_q   <= 4'd0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_MAC;
                        tap_q   <= 4'd0;
                        acc_q   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_q + {{4{prod[29]}}, prod};
                    tap_q <= tap_q + 4'd1;
                    if (tap_q == LAST_TAP) begin
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay line: shifts only on an accepted sample; dropped samples never enter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = NTAPS - 1; k > 0; k--) begin
                x_q[k] <= x_q[k-1];
            end
            x_q[0] <= i14_sample;
        end
    end

    // Coefficient bank: writes land only in IDLE, so a pass never sees a coefficient change mid-sum.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NTAPS; k++) begin
                h_q[k] <= (k == 0) ? 16'sh4000 : 16'sh0000;
            end
        end else if (i_coef_we && (state_q == ST_IDLE)) begin
            h_q[i4_coef_addr] <= i16_coef_data;
        end
    end

    // Output register: result and saturation flag update together, valid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o14_filtered     <= '0;
            o_saturated      <= 1'b0;
            o_filtered_valid <= 1'b0;
        end else begin
            o_filtered_valid <= 1'b0;
            if (state_q == ST_OUT) begin
                o14_filtered     <= sat_val;
                o_saturated      <= sat_flag;
                o_filtered_valid <= 1'b1;
            end
        end
    end

    // Sticky overrun flag: a sample strobe while busy is lost and remembered until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_drop <= 1'b0;
        end else if (i_sample_valid && !o_ready) begin
            o_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_serial_mac_16.sv
// Directed bench for fir_serial_mac_16: drivers push hand-computed results
// into a queue, an output monitor pops and compares on each valid pulse.
module tb_fir_serial_mac_16;

    logic        clk;
    logic        rstn;
    logic [13:0] i14_sample;
    logic        i_sample_valid;
    logic        o_ready;
    logic        i_coef_we;
    logic [3:0]  i4_coef_addr;
    logic [15:0] i16_coef_data;
    logic [13:0] o14_filtered;
    logic        o_filtered_valid;
    logic        o_saturated;
    logic        o_drop;
    logic [1:0]  o2_dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // {saturated, filtered[13:0]}
    logic [14:0] exp_q[$];

    fir_serial_mac_16 dut (
        .clk              (clk),
        .rstn             (rstn),
        .i14_sample       (i14_sample),
        .i_sample_valid   (i_sample_valid),
        .o_ready          (o_ready),
        .i_coef_we        (i_coef_we),
        .i4_coef_addr     (i4_coef_addr),
        .i16_coef_data    (i16_coef_data),
        .o14_filtered     (o14_filtered),
        .o_filtered_valid (o_filtered_valid),
        .o_saturated      (o_saturated),
        .o_drop           (o_drop),
        .o2_dbg_state     (o2_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Leaves the bench at #1 after a posedge with reset released.
    task automatic do_reset();
        rstn           = 1'b0;
        i_sample_valid = 1'b0;
        i14_sample     = '0;
        i_coef_we      = 1'b0;
        i4_coef_addr   = '0;
        i16_coef_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_coef(input int addr, input int data);
        i_coef_we     = 1'b1;
        i4_coef_addr  = 4'(addr);
        i16_coef_data = 16'(data);
        @(posedge clk);
        #1;
        i_coef_we = 1'b0;
    endtask

    // Waits for o_ready, then presents the sample for exactly one edge (E0),
    // optionally with a coefficient write on that same edge.
    task automatic accept(input int s, input bit we, input int addr, input int data);
        int n;
        n = 0;
        while (!o_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_ready) check("ready_timeout", 0, 1);
        i14_sample     = 14'(s);
        i_sample_valid = 1'b1;
        i_coef_we      = we;
        i4_coef_addr   = 4'(addr);
        i16_coef_data  = 16'(data);
        @(posedge clk);
        #1;
        i_sample_valid = 1'b0;
        i_coef_we      = 1'b0;
    endtask

    // Full sample pass: push the expectation, accept, and check the 17-edge
    // latency. With inject set, a sample strobe and a write of h[0] are
    // presented at E5 while the filter is busy.
    task automatic run_sample(input int s, input int exp_y, input bit exp_sat,
                              input bit we, input int wdata, input bit inject);
        int n;
        exp_q.push_back({exp_sat, 14'(exp_y)});
        accept(s, we, 0, wdata);
        n = 0;
        while (!o_ready && n < 40) begin
            if (inject && n == 4) begin
                i14_sample     = 14'd50;
                i_sample_valid = 1'b1;
                i_coef_we      = 1'b1;
                i4_coef_addr   = 4'd0;
                i16_coef_data  = 16'h1000;
            end
            @(posedge clk);
            #1;
            n++;
            if (inject && n == 5) begin
                i_sample_valid = 1'b0;
                i_coef_we      = 1'b0;
            end
        end
        check("latency_to_ready", n, 17);
        check("valid_pulse_at_E17", int'(o_filtered_valid), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (o_filtered_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                check("filtered", int'($signed(o14_filtered)), int'($signed(e[13:0])));
                check("saturated", int'(o_saturated), int'(e[14]));
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset();
        check("rst_ready", int'(o_ready), 1);
        check("rst_filtered", int'(o14_filtered), 0);
        check("rst_valid", int'(o_filtered_valid), 0);
        check("rst_saturated", int'(o_saturated), 0);
        check("rst_drop", int'(o_drop), 0);
        check("rst_state", int'(o2_dbg_state), 0);

        // Pass-through with reset coefficients.
        run_sample(1000, 1000, 1'b0, 1'b0, 0, 1'b0);
        run_sample(-1234, -1234, 1'b0, 1'b0, 0, 1'b0);

        // Four-tap moving sum of an impulse.
        do_reset();
        for (int k = 1; k < 4; k++) write_coef(k, 16'h4000);
        run_sample(100, 100, 1'b0, 1'b0, 0, 1'b0);
        run_sample(0, 100, 1'b0, 1'b0, 0, 1'b0);
        run_sample(0, 100, 1'b0, 1'b0, 0, 1'b0);
        run_sample(0, 100, 1'b0, 1'b0, 0, 1'b0);
        run_sample(0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Rounding with h[0] = 0.5: half-way cases round up.
        do_reset();
        write_coef(0, 16'h2000);
        run_sample(3, 2, 1'b0, 1'b0, 0, 1'b0);
        run_sample(-3, -1, 1'b0, 1'b0, 0, 1'b0);
        run_sample(1, 1, 1'b0, 1'b0, 0, 1'b0);
        run_sample(-1, 0, 1'b0, 1'b0, 0, 1'b0);

        // Saturation at both rails with h[0] = h[1] = 1.0.
        do_reset();
        write_coef(1, 16'h4000);
        run_sample(8191, 8191, 1'b0, 1'b0, 0, 1'b0);
        run_sample(8191, 8191, 1'b1, 1'b0, 0, 1'b0);
        run_sample(-8192, -1, 1'b0, 1'b0, 0, 1'b0);
        run_sample(-8192, -8192, 1'b1, 1'b0, 0, 1'b0);

        // Write on the acceptance edge is used by that same pass.
        do_reset();
        run_sample(1000, 500, 1'b0, 1'b1, 16'h2000, 1'b0);

        // Busy strobe and busy write at E5: sample dropped, h[0] untouched.
        do_reset();
        run_sample(700, 700, 1'b0, 1'b0, 0, 1'b1);
        check("drop_set", int'(o_drop), 1);
        run_sample(300, 300, 1'b0, 1'b0, 0, 1'b0);
        check("drop_sticky", int'(o_drop), 1);

        // Reset in the middle of the MAC pass (at E8).
        do_reset();
        write_coef(0, 16'h2000);
        accept(900, 1'b0, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", int'(o_ready), 1);
        check("midrst_filtered", int'(o14_filtered), 0);
        check("midrst_valid", int'(o_filtered_valid), 0);
        check("midrst_state", int'(o2_dbg_state), 0);
        rstn = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("midrst_no_output", int'(o14_filtered), 0);
        // h[0] back to 1.0 and delay line cleared.
        run_sample(500, 500, 1'b0, 1'b0, 0, 1'b0);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
